// File: rtl/uart_tx_arb_port.sv
// Shared UART transmit port: forwards two clients' requests to a grant arbiter and serializes the granted byte (8N1).
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_arb_port #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_0,
  input  logic [7:0] data_0,
  input  logic       valid_1,
  input  logic [7:0] data_1,
  input  logic       gnt_0,
  input  logic       gnt_1,
  output logic       req_0,
  output logic       req_1,
  output logic       ack_0,
  output logic       ack_1,
  output logic       tx,
  output logic       busy,
  output logic       src
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ack_0_q, ack_0_d;
  logic        ack_1_q, ack_1_d;
  logic        src_q, src_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic bit_end;
  assign bit_end = (baud_q == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    src_d     = src_q;
    ack_0_d   = 1'b0;
    ack_1_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q == S_IDLE) begin
      tx_d      = 1'b1;
      baud_d    = 16'd0;
      bit_idx_d = 3'd0;
      // Client 0 wins whenever both grants are seen together
      if (gnt_0 && valid_0) begin
        shift_d = data_0;
        src_d   = 1'b0;
        ack_0_d = 1'b1;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        state_d = S_START;
`ifdef UART_TX_PARITY_EN
        parity_d = ^data_0;
`endif
      end else if (gnt_1 && valid_1) begin
        shift_d = data_1;
        src_d   = 1'b1;
        ack_1_d = 1'b1;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        state_d = S_START;
`ifdef UART_TX_PARITY_EN
        parity_d = ^data_1;
`endif
      end
    end else if (!bit_end) begin
      baud_d = baud_q + 16'd1;
    end else begin
      baud_d = 16'd0;
      case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
        S_DATA: begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_d   = S_STOP;
          bit_idx_d = 3'd0;
          tx_d      = 1'b1;
        end
`endif
        S_STOP: begin
          tx_d = 1'b1;
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ack_0_q   <= 1'b0;
      ack_1_q   <= 1'b0;
      src_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ack_0_q   <= ack_0_d;
      ack_1_q   <= ack_1_d;
      src_q     <= src_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Requests drop during a frame and during the ack cycle
  assign req_0 = valid_0 & ~busy_q & ~ack_0_q;
  assign req_1 = valid_1 & ~busy_q & ~ack_1_q;
  assign ack_0 = ack_0_q;
  assign ack_1 = ack_1_q;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign src   = src_q;

endmodule

// File: tb/tb_uart_tx_arb_port.sv
// Bench for uart_tx_arb_port: scoreboard of expected {src, byte} frames, decoded from tx by a monitor.
module tb_uart_tx_arb_port;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid_0 = 1'b0, valid_1 = 1'b0, gnt_0 = 1'b0, gnt_1 = 1'b0;
  logic [7:0] data_0 = 8'h00, data_1 = 8'h00;
  logic       req_0, req_1, ack_0, ack_1, tx, busy, src;

  int tests_run = 0;
  int tests_failed = 0;
  int ack0_cnt = 0;
  int ack1_cnt = 0;
  logic [8:0] exp_q[$];

  uart_tx_arb_port #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clock(clock), .reset(reset),
    .valid_0(valid_0), .data_0(data_0), .valid_1(valid_1), .data_1(data_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .req_0(req_0), .req_1(req_1),
    .ack_0(ack_0), .ack_1(ack_1), .tx(tx), .busy(busy), .src(src)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_ack(input bit c);
    int n = 0;
    while (((c ? ack_1 : ack_0) !== 1'b1) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check(c ? "ack1_seen" : "ack0_seen", {31'd0, (c ? ack_1 : ack_0)}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin : ack_counter
    forever begin
      @(negedge clock);
      if (ack_0 === 1'b1) ack0_cnt++;
      if (ack_1 === 1'b1) ack1_cnt++;
    end
  end

  initial begin : monitor
    logic [11:0] obs, exp_f;
    logic [8:0]  item;
    int len, glitches;
    forever begin
      @(negedge clock);
      if (!reset && busy === 1'b1) begin
        len = 0;
        glitches = 0;
        obs = '1;
        while (busy === 1'b1 && !reset && len < 4 * FRAME_CLKS) begin
          if (len / CPB < 12) begin
            if (len % CPB == 1) obs[len / CPB] = tx;
            else if (len % CPB > 1 && tx !== obs[len / CPB]) glitches++;
          end
          len++;
          @(negedge clock);
        end
        if (!reset) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
          end else begin
            item = exp_q.pop_front();
            exp_f = '1;
            exp_f[0] = 1'b0;
            exp_f[8:1] = item[7:0];
`ifdef UART_TX_PARITY_EN
            exp_f[9] = ^item[7:0];
`endif
            $display("[TB] frame src=%0d data=%02h bits=%03h len=%0d", src, item[7:0], obs, len);
            check("frame_bits", {20'd0, obs}, {20'd0, exp_f});
            check("frame_len", len, FRAME_CLKS);
            check("bit_stable", glitches, 0);
            check("frame_src", {31'd0, src}, {31'd0, item[8]});
            check("idle_tx", {31'd0, tx}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int a;
    tick(2);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack0", {31'd0, ack_0}, 32'd0);
    check("rst_ack1", {31'd0, ack_1}, 32'd0);
    check("rst_src", {31'd0, src}, 32'd0);
    reset = 1'b0;
    tick(1);

    // valid without grant: request raised, nothing sent
    valid_0 = 1'b1; data_0 = 8'h11;
    tick(3);
    check("nogrant_busy", {31'd0, busy}, 32'd0);
    check("nogrant_req0", {31'd0, req_0}, 32'd1);
    check("nogrant_tx", {31'd0, tx}, 32'd1);

    // client 0, 0xA5
    gnt_0 = 1'b1; data_0 = 8'hA5;
    exp_q.push_back({1'b0, 8'hA5});
    wait_ack(1'b0);
    check("t2_src", {31'd0, src}, 32'd0);
    valid_0 = 1'b0;
    wait_idle();
    check("t2_ack0_cnt", ack0_cnt, 1);

    // client 1, 0x3C
    gnt_0 = 1'b0; gnt_1 = 1'b1; valid_1 = 1'b1; data_1 = 8'h3C;
    exp_q.push_back({1'b1, 8'h3C});
    wait_ack(1'b1);
    check("t3_src", {31'd0, src}, 32'd1);
    valid_1 = 1'b0;
    wait_idle();
    check("t3_ack1_cnt", ack1_cnt, 1);

    // both grants, both valid: client 0 wins, data_1 change ignored
    gnt_0 = 1'b1; gnt_1 = 1'b1;
    valid_0 = 1'b1; data_0 = 8'h5A;
    valid_1 = 1'b1; data_1 = 8'hC3;
    exp_q.push_back({1'b0, 8'h5A});
    wait_ack(1'b0);
    valid_0 = 1'b0;
    tick(8);
    data_1 = 8'hFF;
    check("t4_req1_busy", {31'd0, req_1}, 32'd0);
    tick(8);
    valid_1 = 1'b0;
    wait_idle();
    check("t4_ack1_cnt", ack1_cnt, 1);
    check("t4_ack0_cnt", ack0_cnt, 2);

    // back-to-back frames from client 0
    gnt_1 = 1'b0;
    valid_0 = 1'b1; data_0 = 8'h01;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    wait_ack(1'b0);
    data_0 = 8'h02;
    tick(2);
    check("t5_req0_busy", {31'd0, req_0}, 32'd0);
    wait_idle();
    check("t5_gap_tx", {31'd0, tx}, 32'd1);
    tick(1);
    check("t5_next_busy", {31'd0, busy}, 32'd1);
    check("t5_next_tx", {31'd0, tx}, 32'd0);
    wait_ack(1'b0);
    valid_0 = 1'b0;
    wait_idle();
    check("t5_ack0_cnt", ack0_cnt, 4);

`ifdef UART_TX_PARITY_EN
    valid_0 = 1'b1; data_0 = 8'h07;
    exp_q.push_back({1'b0, 8'h07});
    wait_ack(1'b0);
    valid_0 = 1'b0;
    wait_idle();
    tick(1);
    valid_0 = 1'b1; data_0 = 8'h03;
    exp_q.push_back({1'b0, 8'h03});
    wait_ack(1'b0);
    valid_0 = 1'b0;
    wait_idle();
`endif

    // reset during data bit 1 of an 0xA5 frame
    tick(1);
    valid_0 = 1'b1; data_0 = 8'hA5;
    exp_q.push_back({1'b0, 8'hA5});
    wait_ack(1'b0);
    valid_0 = 1'b0;
    a = ack0_cnt;
    tick(9);
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ack0", {31'd0, ack_0}, 32'd0);
    tick(2);
    exp_q.delete();
    reset = 1'b0;
    tick(3);
    check("rst_no_ack", ack0_cnt, a);
    check("rst_req0_low", {31'd0, req_0}, 32'd0);
    gnt_0 = 1'b0; valid_0 = 1'b1;
    #1;
    check("rst_req0_high", {31'd0, req_0}, 32'd1);
    tick(1);
    gnt_0 = 1'b1; data_0 = 8'h96;
    exp_q.push_back({1'b0, 8'h96});
    wait_ack(1'b0);
    valid_0 = 1'b0;
    wait_idle();
    tick(2);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
